// File: rtl/mem_stage_pkg.sv
// Shared definitions for the pipeline MEM stage: FSM states, control-bit
// positions in the EX/MEM fields and the default bus timeout.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

  // Bit positions inside MEM_m
  localparam int MEM_READ  = 0;
  localparam int MEM_WRITE = 1;

  // Bit positions inside MEM_wb / MEM_wb_in
  localparam int WB_REG_WRITE  = 0;
  localparam int WB_MEM_TO_REG = 1;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/mem_wait_counter.sv
// Bus wait counter for the MEM stage. Counts up while enabled, sticks at
// TIMEOUT_CYCLES-1, and flags that value as terminal count.
module mem_wait_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic startin_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int             W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [W-1:0]   TC = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] r_count;
  logic         w_tc;

  assign w_tc = (r_count == TC);
  assign o_tc = w_tc;

  // Clear has priority; counting saturates at terminal count.
  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_tc) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: performs data-memory loads/stores over a req/ack bus,
// stalls upstream and bubbles MEM/WB while an access is outstanding.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no access in flight; pass-through or launch a new access
// BUSY    | dmem_req held high, waiting for dmem_ack or timeout
// DONE    | result presented to MEM/WB for one cycle, upstream advances
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        startin_n,
  input  logic [1:0]  MEM_m,
  input  logic [1:0]  MEM_wb_in,
  input  logic [31:0] MEM_alu_result,
  input  logic [31:0] MEM_write_data,
  input  logic [4:0]  MEM_mux_out_in,
  output logic [1:0]  MEM_wb,
  output logic [31:0] MEM_mem_data,
  output logic [31:0] MEM_alu_result_out,
  output logic [4:0]  MEM_mux_out,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        err_misalign,
  output logic        err_timeout
);

  mem_state_e  r_state;
  mem_state_e  w_state_nxt;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_data_q;
  logic        r_timed_out;
  logic        r_err_misalign;
  logic        r_err_timeout;

  logic        w_op;
  logic        w_is_write;
  logic        w_misalign;
  logic        w_idle;
  logic        w_busy;
  logic        w_done;
  logic        w_start;
  logic        w_bad_op;
  logic        w_tc;

  assign w_op       = MEM_m[MEM_READ] | MEM_m[MEM_WRITE];
  assign w_is_write = MEM_m[MEM_WRITE];
  assign w_misalign = |MEM_alu_result[1:0];
  assign w_idle     = (r_state == ST_IDLE);
  assign w_busy     = (r_state == ST_BUSY);
  assign w_done     = (r_state == ST_DONE);
  assign w_start    = w_idle & w_op & ~w_misalign;
  assign w_bad_op   = w_idle & w_op &  w_misalign;

  mem_wait_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_counter (
    .clk       (clk),
    .startin_n (startin_n),
    .i_clr     (w_start),
    .i_en      (w_busy),
    .o_tc      (w_tc)
  );

  // Next-state selection; ack has priority over a same-cycle timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start)           w_state_nxt = ST_BUSY;
      ST_BUSY: if (dmem_ack || w_tc)  w_state_nxt = ST_DONE;
      ST_DONE:                        w_state_nxt = ST_IDLE;
      default:                        w_state_nxt = ST_IDLE;
    endcase
  end

  // State, bus-side registers, captured load data and error pulses.
  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      r_state        <= ST_IDLE;
      r_req          <= 1'b0;
      r_we           <= 1'b0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_data_q       <= '0;
      r_timed_out    <= 1'b0;
      r_err_misalign <= 1'b0;
      r_err_timeout  <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_err_misalign <= w_bad_op;
      r_err_timeout  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_req       <= 1'b1;
            r_we        <= w_is_write;
            r_addr      <= {MEM_alu_result[31:2], 2'b00};
            r_wdata     <= MEM_write_data;
            r_timed_out <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            r_req    <= 1'b0;
            r_we     <= 1'b0;
            // Stores (including read+write, where write wins) return no data.
            r_data_q <= r_we ? '0 : dmem_rdata;
          end else if (w_tc) begin
            r_req         <= 1'b0;
            r_we          <= 1'b0;
            r_data_q      <= '0;
            r_timed_out   <= 1'b1;
            r_err_timeout <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Pipeline-side outputs: stall/bubble while an access is pending.
  always_comb begin
    mem_stall    = w_start | w_busy;
    MEM_mem_data = w_done ? r_data_q : '0;
    MEM_wb       = 2'b00;
    if (w_idle && !w_op) begin
      MEM_wb = MEM_wb_in;
    end else if (w_done && !r_timed_out) begin
      MEM_wb = MEM_wb_in;
    end
  end

  assign MEM_alu_result_out = MEM_alu_result;
  assign MEM_mux_out        = MEM_mux_out_in;
  assign dmem_req           = r_req;
  assign dmem_we            = r_we;
  assign dmem_addr          = r_addr;
  assign dmem_wdata         = r_wdata;
  assign err_misalign       = r_err_misalign;
  assign err_timeout        = r_err_timeout;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage. The driver knows, for every
// instruction it issues, when (or whether) the bus acknowledges, and from
// that derives the per-cycle expected outputs of the MEM stage.
module tb_mem_access_stage;

  localparam int TMO = 4;

  logic        clk;
  logic        startin_n;
  logic [1:0]  MEM_m;
  logic [1:0]  MEM_wb_in;
  logic [31:0] MEM_alu_result;
  logic [31:0] MEM_write_data;
  logic [4:0]  MEM_mux_out_in;
  logic [1:0]  MEM_wb;
  logic [31:0] MEM_mem_data;
  logic [31:0] MEM_alu_result_out;
  logic [4:0]  MEM_mux_out;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        err_misalign;
  logic        err_timeout;

  mem_access_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk                (clk),
    .startin_n          (startin_n),
    .MEM_m              (MEM_m),
    .MEM_wb_in          (MEM_wb_in),
    .MEM_alu_result     (MEM_alu_result),
    .MEM_write_data     (MEM_write_data),
    .MEM_mux_out_in     (MEM_mux_out_in),
    .MEM_wb             (MEM_wb),
    .MEM_mem_data       (MEM_mem_data),
    .MEM_alu_result_out (MEM_alu_result_out),
    .MEM_mux_out        (MEM_mux_out),
    .mem_stall          (mem_stall),
    .dmem_req           (dmem_req),
    .dmem_we            (dmem_we),
    .dmem_addr          (dmem_addr),
    .dmem_wdata         (dmem_wdata),
    .dmem_ack           (dmem_ack),
    .dmem_rdata         (dmem_rdata),
    .err_misalign       (err_misalign),
    .err_timeout        (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic [1:0]  wb;
    logic [31:0] mdata;
    logic        req;
    logic        bus;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        emis;
    logic        eto;
    logic [31:0] alu;
    logic [4:0]  mux;
  } exp_t;

  exp_t expq[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mis_pending = 1'b0;
  int   stall_cnt, req_cnt, mis_cnt, to_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Per-cycle comparison against whatever the driver expects for this cycle.
  always @(negedge clk) begin : compare
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("stall",        32'(mem_stall),    32'(e.stall));
      chk("wb",           32'(MEM_wb),       32'(e.wb));
      chk("mem_data",     MEM_mem_data,      e.mdata);
      chk("req",          32'(dmem_req),     32'(e.req));
      if (e.bus) begin
        chk("we",         32'(dmem_we),      32'(e.we));
        chk("addr",       dmem_addr,         e.addr);
        chk("wdata",      dmem_wdata,        e.wdata);
      end
      chk("err_misalign", 32'(err_misalign), 32'(e.emis));
      chk("err_timeout",  32'(err_timeout),  32'(e.eto));
      chk("alu_fwd",      MEM_alu_result_out, e.alu);
      chk("mux_fwd",      32'(MEM_mux_out),  32'(e.mux));
    end
  end

  // Raw event counts, compared against hand-computed literals.
  always @(negedge clk) begin
    if (startin_n) begin
      if (mem_stall)    stall_cnt++;
      if (dmem_req)     req_cnt++;
      if (err_misalign) mis_cnt++;
      if (err_timeout)  to_cnt++;
    end
  end

  task automatic clr_counts();
    stall_cnt = 0; req_cnt = 0; mis_cnt = 0; to_cnt = 0;
  endtask

  // Issue one instruction. d = req cycle (0-based) in which ack arrives,
  // d < 0 means the bus never answers; for non-memory ops d >= 0 puts a
  // stray ack on the bus. rst_at >= 0 asserts reset in that residence cycle.
  task automatic run_op(input logic [1:0] m, input logic [1:0] wbi,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] mux, input int d,
                        input logic [31:0] rd, input int rst_at);
    exp_t e;
    int   last;
    bit   to;
    bit   wr;
    MEM_m = m; MEM_wb_in = wbi; MEM_alu_result = alu;
    MEM_write_data = wd; MEM_mux_out_in = mux;
    e = '{default: '0};
    e.alu = alu;
    e.mux = mux;
    if (m == 2'b00 || alu[1:0] != 2'b00) begin
      dmem_ack   = (m == 2'b00) && (d >= 0);
      dmem_rdata = 32'hBAD0_0000;
      e.wb   = (m == 2'b00) ? wbi : 2'b00;
      e.emis = mis_pending;
      expq.push_back(e);
      mis_pending = (m != 2'b00);
      @(posedge clk); #1;
      dmem_ack = 1'b0;
      return;
    end
    to   = (d < 0);
    wr   = m[1];
    last = to ? TMO + 1 : d + 2;
    for (int i = 0; i <= last; i++) begin
      if (i == rst_at) begin
        #1; startin_n = 1'b0; #1;
        chk("rst_req_async", 32'(dmem_req),    32'd0);
        chk("rst_err_to",    32'(err_timeout), 32'd0);
        chk("rst_addr",      dmem_addr,        32'd0);
        MEM_m = 2'b00; #1;
        chk("rst_idle_stall", 32'(mem_stall),  32'd0);
        chk("rst_idle_wb",    32'(MEM_wb),     32'(wbi));
        @(posedge clk); #1;
        startin_n   = 1'b1;
        mis_pending = 1'b0;
        dmem_ack    = 1'b0;
        return;
      end
      dmem_ack   = (i == d + 1) || (to && i == last);
      dmem_rdata = (i == d + 1) ? rd : (32'hBAD0_0000 | 32'(i));
      e.stall = (i < last);
      e.wb    = (i == last && !to) ? wbi : 2'b00;
      e.mdata = (i == last && !to && !wr) ? rd : 32'd0;
      e.req   = (i >= 1 && i < last);
      e.bus   = e.req;
      e.we    = wr;
      e.addr  = alu;
      e.wdata = wd;
      e.emis  = (i == 0) ? mis_pending : 1'b0;
      e.eto   = to && (i == last);
      expq.push_back(e);
      @(posedge clk); #1;
    end
    mis_pending = 1'b0;
    dmem_ack    = 1'b0;
  endtask

  initial begin
    startin_n = 1'b0;
    MEM_m = 2'b00; MEM_wb_in = 2'b10; MEM_alu_result = '0;
    MEM_write_data = '0; MEM_mux_out_in = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    clr_counts();
    @(posedge clk); #1;
    chk("reset_req",   32'(dmem_req),     32'd0);
    chk("reset_we",    32'(dmem_we),      32'd0);
    chk("reset_addr",  dmem_addr,         32'd0);
    chk("reset_wdata", dmem_wdata,        32'd0);
    chk("reset_emis",  32'(err_misalign), 32'd0);
    chk("reset_eto",   32'(err_timeout),  32'd0);
    chk("reset_stall", 32'(mem_stall),    32'd0);
    chk("reset_wb",    32'(MEM_wb),       32'h2);
    chk("reset_mdata", MEM_mem_data,      32'd0);
    startin_n = 1'b1;

    // Non-memory op, then a non-memory op with a stray ack.
    clr_counts();
    run_op(2'b00, 2'b01, 32'h10, 32'h0, 5'd5, -1, 32'h0, -1);
    run_op(2'b00, 2'b10, 32'h20, 32'h0, 5'd6,  0, 32'h0, -1);
    chk("noop_req_cnt",   32'(req_cnt),   32'd0);
    chk("noop_stall_cnt", 32'(stall_cnt), 32'd0);

    // Load, ack two cycles after the first req cycle.
    clr_counts();
    run_op(2'b01, 2'b11, 32'h40, 32'h0, 5'd7, 2, 32'hCAFE_F00D, -1);
    chk("load_stall_cnt", 32'(stall_cnt), 32'd4);
    chk("load_req_cnt",   32'(req_cnt),   32'd3);

    // Store, ack in first req cycle.
    clr_counts();
    run_op(2'b10, 2'b00, 32'h44, 32'h1234_5678, 5'd8, 0, 32'hFFFF_0000, -1);
    chk("store_stall_cnt", 32'(stall_cnt), 32'd2);
    chk("store_req_cnt",   32'(req_cnt),   32'd1);

    // Misaligned load followed by a plain instruction.
    clr_counts();
    run_op(2'b01, 2'b01, 32'h42,  32'h0, 5'd9,  -1, 32'h0, -1);
    run_op(2'b00, 2'b01, 32'h100, 32'h0, 5'd10, -1, 32'h0, -1);
    chk("mis_pulse_cnt", 32'(mis_cnt),   32'd1);
    chk("mis_req_cnt",   32'(req_cnt),   32'd0);
    chk("mis_stall_cnt", 32'(stall_cnt), 32'd0);

    // Bus never answers.
    clr_counts();
    run_op(2'b01, 2'b01, 32'h80, 32'h0, 5'd11, -1, 32'h0, -1);
    chk("tmo_req_cnt",   32'(req_cnt),   32'd4);
    chk("tmo_stall_cnt", 32'(stall_cnt), 32'd5);
    chk("tmo_pulse_cnt", 32'(to_cnt),    32'd1);

    // Read and write both set: behaves as a store.
    run_op(2'b11, 2'b11, 32'h48, 32'hAAAA_5555, 5'd12, 1, 32'h0000_0055, -1);

    // Reset in the second req cycle, then a normal load.
    run_op(2'b01, 2'b01, 32'h50, 32'h0, 5'd13, 3, 32'h1, 2);
    clr_counts();
    run_op(2'b01, 2'b01, 32'h60, 32'h0, 5'd14, 1, 32'hA5A5_A5A5, -1);
    chk("post_rst_stall_cnt", 32'(stall_cnt), 32'd3);
    chk("post_rst_req_cnt",   32'(req_cnt),   32'd2);
    chk("post_rst_to_cnt",    32'(to_cnt),    32'd0);

    // Back-to-back accesses with no idle cycle between them.
    run_op(2'b01, 2'b11, 32'h64, 32'h0,       5'd15, 0, 32'h0BAD_CAFE, -1);
    run_op(2'b10, 2'b00, 32'h68, 32'h7777_0001, 5'd16, 3, 32'h0, -1);
    run_op(2'b00, 2'b01, 32'h6C, 32'h0,       5'd17, -1, 32'h0, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
